// File: rtl/axi_mem_arbiter_pkg.sv
// Shared types and AXI constants for the two-requester memory arbiter.
package axi_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR0,
    ST_R0,
    ST_AR1,
    ST_R1,
    ST_WR,
    ST_WB
  } state_e;

  localparam int unsigned ID_M0 = 0;
  localparam int unsigned ID_M1 = 1;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_arb_beat_check.sv
// Read beat counter plus response-side protocol checking with a sticky error flag.
module axi_arb_beat_check
  import axi_mem_arbiter_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  state_e          i_state,
  input  logic            i_ar_hs,
  input  logic [7:0]      i_arlen,
  input  logic            i_rvalid,
  input  logic            i_rready,
  input  logic            i_rlast,
  input  logic [ID_W-1:0] i_rid,
  input  logic            i_bvalid,
  input  logic            i_bready,
  input  logic [ID_W-1:0] i_bid,
  output logic            o_protocol_err
);

  logic [7:0]      r_cnt;
  logic            r_err;
  logic [ID_W-1:0] w_exp_id;
  logic            w_r_beat;
  logic            w_b_hs;
  logic            w_early;
  logic            w_err_now;

  always_comb begin
    w_exp_id  = (i_state == ST_R0) ? ID_W'(ID_M0) : ID_W'(ID_M1);
    w_r_beat  = i_rvalid & i_rready & ((i_state == ST_R0) | (i_state == ST_R1));
    w_b_hs    = i_bvalid & i_bready & (i_state == ST_WB);
    // A response before the matching request phase has finished is always an error
    w_early   = (i_rvalid | i_bvalid) &
                (i_state inside {ST_IDLE, ST_AR0, ST_AR1, ST_WR});
    w_err_now = w_early
              | (w_r_beat & ((i_rid != w_exp_id)
                             | (i_rlast & (r_cnt != 8'd0))
                             | (!i_rlast & (r_cnt == 8'd0))))
              | (w_b_hs & (i_bid != w_exp_id));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_ar_hs) begin
        r_cnt <= i_arlen;
      end else if (w_r_beat && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_err_now) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_protocol_err = r_err;

endmodule

// File: rtl/axi_mem_arbiter.sv
// Grants one AXI4 transaction at a time between fetch (M0) and load/store (M1)
// onto the downstream master port, routing R/B responses back to the owner.
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic [ID_W-1:0]     io_master_rid,
  input  logic                io_master_rlast,
  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid,
  output logic                busy,
  output logic                protocol_err
);

  state_e r_state;
  logic   r_rr_m1;
  logic   r_aw_done;
  logic   r_w_done;
  logic   r_busy;

  logic w_ar0, w_ar1, w_r0, w_r1, w_wr, w_wb;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

  assign w_ar0 = (r_state == ST_AR0);
  assign w_ar1 = (r_state == ST_AR1);
  assign w_r0  = (r_state == ST_R0);
  assign w_r1  = (r_state == ST_R1);
  assign w_wr  = (r_state == ST_WR);
  assign w_wb  = (r_state == ST_WB);

  // Read address channel
  assign io_master_arvalid = (w_ar0 & m0_arvalid) | (w_ar1 & m1_arvalid);
  assign io_master_araddr  = w_ar1 ? m1_araddr : m0_araddr;
  assign io_master_arid    = w_ar1 ? ID_W'(ID_M1) : ID_W'(ID_M0);
  assign io_master_arlen   = w_ar1 ? 8'd0 : m0_arlen;
  assign io_master_arsize  = w_ar1 ? SIZE_4B : m0_arsize;
  assign io_master_arburst = w_ar1 ? BURST_INCR : m0_arburst;
  assign m0_arready        = w_ar0 & io_master_arready;
  assign m1_arready        = w_ar1 & io_master_arready;

  // Read data channel
  assign io_master_rready  = (w_r0 & m0_rready) | (w_r1 & m1_rready);
  assign m0_rvalid         = w_r0 & io_master_rvalid;
  assign m0_rdata          = io_master_rdata;
  assign m0_rresp          = io_master_rresp;
  assign m0_rlast          = io_master_rlast;
  assign m1_rvalid         = w_r1 & io_master_rvalid;
  assign m1_rdata          = io_master_rdata;
  assign m1_rresp          = io_master_rresp;

  // Write address/data channels run independently inside WR
  assign io_master_awvalid = w_wr & m1_awvalid & ~r_aw_done;
  assign io_master_awaddr  = m1_awaddr;
  assign io_master_awid    = ID_W'(ID_M1);
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = SIZE_4B;
  assign io_master_awburst = BURST_INCR;
  assign m1_awready        = w_wr & io_master_awready & ~r_aw_done;
  assign io_master_wvalid  = w_wr & m1_wvalid & ~r_w_done;
  assign io_master_wdata   = m1_wdata;
  assign io_master_wstrb   = m1_wstrb;
  assign io_master_wlast   = 1'b1;
  assign m1_wready         = w_wr & io_master_wready & ~r_w_done;

  // Write response channel
  assign io_master_bready  = w_wb & m1_bready;
  assign m1_bvalid         = w_wb & io_master_bvalid;
  assign m1_bresp          = io_master_bresp;

  assign w_ar_hs = io_master_arvalid & io_master_arready;
  assign w_r_hs  = io_master_rvalid & io_master_rready;
  assign w_aw_hs = io_master_awvalid & io_master_awready;
  assign w_w_hs  = io_master_wvalid & io_master_wready;
  assign w_b_hs  = io_master_bvalid & io_master_bready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_rr_m1   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          // Pointer records the master that should win the next read tie
          if (m1_awvalid) begin
            r_state <= ST_WR;
            r_busy  <= 1'b1;
          end else if (m0_arvalid && (!m1_arvalid || !r_rr_m1)) begin
            r_state <= ST_AR0;
            r_rr_m1 <= 1'b1;
            r_busy  <= 1'b1;
          end else if (m1_arvalid) begin
            r_state <= ST_AR1;
            r_rr_m1 <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_AR0: if (w_ar_hs) r_state <= ST_R0;
        ST_AR1: if (w_ar_hs) r_state <= ST_R1;
        ST_R0, ST_R1: begin
          if (w_r_hs && io_master_rlast) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WR: begin
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_state   <= ST_WB;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        ST_WB: begin
          if (w_b_hs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;

  axi_arb_beat_check #(
    .ID_W(ID_W)
  ) u_beat_check (
    .i_clk          (clock),
    .i_rst_n        (reset),
    .i_state        (r_state),
    .i_ar_hs        (w_ar_hs),
    .i_arlen        (io_master_arlen),
    .i_rvalid       (io_master_rvalid),
    .i_rready       (io_master_rready),
    .i_rlast        (io_master_rlast),
    .i_rid          (io_master_rid),
    .i_bvalid       (io_master_bvalid),
    .i_bready       (io_master_bready),
    .i_bid          (io_master_bid),
    .o_protocol_err (protocol_err)
  );

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scenario bench for axi_mem_arbiter: AR grants and R beats are scoreboarded by queue.
module tb_axi_mem_arbiter;
  import axi_mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_araddr;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst;
  logic        m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready;
  logic [31:0] m1_araddr;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_bvalid, m1_bready;
  logic [1:0]  m1_bresp;
  logic        io_master_arvalid, io_master_arready;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rvalid, io_master_rready, io_master_rlast;
  logic [31:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic [3:0]  io_master_rid;
  logic        io_master_awvalid, io_master_awready;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  logic        io_master_wvalid, io_master_wready, io_master_wlast;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_bvalid, io_master_bready;
  logic [1:0]  io_master_bresp;
  logic [3:0]  io_master_bid;
  logic        busy, protocol_err;

  axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rid(io_master_rid), .io_master_rlast(io_master_rlast),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct packed { logic [3:0] id; logic [31:0] addr; } ar_t;
  typedef struct packed { logic dest; logic [31:0] data; } rb_t;
  ar_t ar_q[$];
  rb_t r_q[$];

  // Scoreboard monitor: inputs change on negedge, handshakes are judged 2ns later
  always @(negedge clock) begin
    ar_t ea;
    rb_t er;
    #2;
    if (reset && io_master_arvalid && io_master_arready) begin
      checks++;
      if (ar_q.size() == 0) begin
        failures++;
        $display("FAIL ar_unexpected got id=%0d addr=%h", io_master_arid, io_master_araddr);
      end else begin
        ea = ar_q.pop_front();
        if (io_master_arid !== ea.id || io_master_araddr !== ea.addr) begin
          failures++;
          $display("FAIL ar_grant got id=%0d addr=%h exp id=%0d addr=%h",
                   io_master_arid, io_master_araddr, ea.id, ea.addr);
        end
      end
    end
    if (reset && ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready))) begin
      checks++;
      if (r_q.size() == 0) begin
        failures++;
        $display("FAIL r_unexpected got m0=%0b m1=%0b data=%h", m0_rvalid, m1_rvalid, io_master_rdata);
      end else begin
        er = r_q.pop_front();
        if ((er.dest ? m1_rvalid : m0_rvalid) !== 1'b1 || (er.dest ? m0_rvalid : m1_rvalid) !== 1'b0 ||
            (er.dest ? m1_rdata : m0_rdata) !== er.data) begin
          failures++;
          $display("FAIL r_route got m0=%0b m1=%0b data=%h exp dest=M%0d data=%h",
                   m0_rvalid, m1_rvalid, io_master_rdata, er.dest, er.data);
        end
      end
    end
  end

  task automatic wait_arvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (io_master_arvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_arvalid = 0; m0_araddr = '0; m0_arlen = '0; m0_arsize = SIZE_4B; m0_arburst = BURST_INCR;
    m0_rready = 1; m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
    m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_bready = 1;
    io_master_arready = 1; io_master_awready = 1; io_master_wready = 1;
    io_master_rvalid = 0; io_master_rdata = '0; io_master_rresp = RESP_OKAY;
    io_master_rid = '0; io_master_rlast = 0;
    io_master_bvalid = 0; io_master_bresp = RESP_OKAY; io_master_bid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Drive one downstream R beat at the current negedge and expect it at dest
  task automatic drive_beat(input logic dest, input logic [31:0] data, input logic last,
                            input logic [3:0] rid);
    io_master_rvalid = 1; io_master_rdata = data; io_master_rlast = last; io_master_rid = rid;
    r_q.push_back('{dest: dest, data: data});
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy, protocol_err, io_master_arvalid, io_master_awvalid, io_master_wvalid,
         io_master_rready, io_master_bready, m0_arready, m1_arready, m1_awready} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b err=%0b arv=%0b awv=%0b exp all 0",
               busy, protocol_err, io_master_arvalid, io_master_awvalid);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic id;
    do_reset();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h1000_0000; m0_arlen = 0;
    m1_arvalid = 1; m1_araddr = 32'h2000_0040;
    for (int k = 0; k < 4; k++) begin
      id = k[0];
      ar_q.push_back('{id: {3'b0, id}, addr: id ? 32'h2000_0040 : 32'h1000_0000});
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      id = k[0];
      wait_arvalid(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_timeout got arvalid=0 exp grant %0d", k);
      end
      @(negedge clock);
      drive_beat(id, 32'hA0 + k, 1'b1, {3'b0, id});
      @(negedge clock);
      io_master_rvalid = 0;
      #1;
    end
    m0_arvalid = 0; m1_arvalid = 0;
    checks++;
    if (protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL rr_err got=%0b exp=0", protocol_err);
    end
  endtask

  task automatic test_m0_burst();
    bit ok;
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h3000_0000; m0_arlen = 8'd3;
    ar_q.push_back('{id: 4'd0, addr: 32'h3000_0000});
    #1;
    wait_arvalid(ok);
    checks++;
    if (!ok || io_master_arlen !== 8'd3 || io_master_arsize !== SIZE_4B) begin
      failures++;
      $display("FAIL burst_ar got ok=%0b arlen=%0d arsize=%0d exp 1/3/2", ok, io_master_arlen, io_master_arsize);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      m0_arvalid = 0;
      drive_beat(1'b0, 32'hB000 + b, b == 3, 4'd0);
    end
    #1;
    checks++;
    if (busy !== 1'b1 || m0_rlast !== 1'b1) begin
      failures++;
      $display("FAIL burst_last_beat got busy=%0b rlast=%0b exp 1/1", busy, m0_rlast);
    end
    @(negedge clock);
    io_master_rvalid = 0; io_master_rlast = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL burst_done got busy=%0b err=%0b exp 0/0", busy, protocol_err);
    end
  endtask

  task automatic test_write_first();
    bit ok;
    @(negedge clock);
    m1_awvalid = 1; m1_awaddr = 32'h4000_0010;
    m1_arvalid = 1; m1_araddr = 32'h4000_0020;
    m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011;
    ar_q.push_back('{id: 4'd1, addr: 32'h4000_0020});
    @(negedge clock);
    #1;
    checks++;
    if (io_master_awvalid !== 1'b1 || io_master_awid !== 4'd1 || io_master_awlen !== 8'd0 ||
        io_master_arvalid !== 1'b0 || m1_arready !== 1'b0) begin
      failures++;
      $display("FAIL write_aw got awv=%0b awid=%0d awlen=%0d arv=%0b exp 1/1/0/0",
               io_master_awvalid, io_master_awid, io_master_awlen, io_master_arvalid);
    end
    @(negedge clock);
    m1_awvalid = 0;
    repeat (2) @(negedge clock);
    m1_wvalid = 1;
    #1;
    checks++;
    if (io_master_wvalid !== 1'b1 || io_master_wlast !== 1'b1 || io_master_wstrb !== 4'b0011 ||
        io_master_wdata !== 32'hDEAD_BEEF || io_master_awvalid !== 1'b0) begin
      failures++;
      $display("FAIL write_w got wv=%0b wlast=%0b wstrb=%b wdata=%h exp 1/1/0011/deadbeef",
               io_master_wvalid, io_master_wlast, io_master_wstrb, io_master_wdata);
    end
    @(negedge clock);
    m1_wvalid = 0;
    io_master_bvalid = 1; io_master_bid = 4'd1; io_master_bresp = 2'b10;
    #1;
    checks++;
    if (m1_bvalid !== 1'b1 || m1_bresp !== 2'b10 || io_master_bready !== 1'b1 ||
        io_master_arvalid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL write_b got bvalid=%0b bresp=%0d bready=%0b arv=%0b exp 1/2/1/0",
               m1_bvalid, m1_bresp, io_master_bready, io_master_arvalid);
    end
    @(negedge clock);
    io_master_bvalid = 0; io_master_bresp = RESP_OKAY;
    #1;
    checks++;
    if (io_master_arvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL write_gap got arv=%0b busy=%0b exp 0/0", io_master_arvalid, busy);
    end
    wait_arvalid(ok);
    checks++;
    if (!ok || io_master_arlen !== 8'd0 || io_master_arburst !== BURST_INCR) begin
      failures++;
      $display("FAIL write_then_read got ok=%0b arlen=%0d arburst=%0d exp 1/0/1",
               ok, io_master_arlen, io_master_arburst);
    end
    @(negedge clock);
    m1_arvalid = 0;
    drive_beat(1'b1, 32'h5555_0001, 1'b1, 4'd1);
    @(negedge clock);
    io_master_rvalid = 0; io_master_rlast = 0;
    #1;
    checks++;
    if (protocol_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL write_read_done got err=%0b busy=%0b exp 0/0", protocol_err, busy);
    end
  endtask

  task automatic test_protocol_err();
    bit ok;
    do_reset();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h3000_0100; m0_arlen = 8'd3;
    ar_q.push_back('{id: 4'd0, addr: 32'h3000_0100});
    #1;
    wait_arvalid(ok);
    @(negedge clock);
    m0_arvalid = 0;
    drive_beat(1'b0, 32'hC000, 1'b0, 4'd0);
    @(negedge clock);
    drive_beat(1'b0, 32'hC001, 1'b1, 4'd0);
    @(negedge clock);
    io_master_rvalid = 0; io_master_rlast = 0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (protocol_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_early_rlast got err=%0b busy=%0b exp 1/0", protocol_err, busy);
    end
    do_reset();
    #1;
    checks++;
    if (protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared got=%0b exp=0", protocol_err);
    end
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h3000_0200; m0_arlen = 8'd0;
    ar_q.push_back('{id: 4'd0, addr: 32'h3000_0200});
    #1;
    wait_arvalid(ok);
    @(negedge clock);
    m0_arvalid = 0;
    drive_beat(1'b0, 32'hC100, 1'b1, 4'd5);
    @(negedge clock);
    io_master_rvalid = 0; io_master_rlast = 0; io_master_rid = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (protocol_err !== 1'b1) begin
      failures++;
      $display("FAIL err_bad_rid got=%0b exp=1", protocol_err);
    end
  endtask

  task automatic test_reset_midburst();
    bit ok;
    do_reset();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h3000_0300; m0_arlen = 8'd3;
    ar_q.push_back('{id: 4'd0, addr: 32'h3000_0300});
    #1;
    wait_arvalid(ok);
    @(negedge clock);
    m0_arvalid = 0;
    drive_beat(1'b0, 32'hD000, 1'b0, 4'd0);
    @(negedge clock);
    io_master_rdata = 32'hD001;
    reset = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, io_master_rready, io_master_arvalid, busy, protocol_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_async got m0_rv=%0b rready=%0b busy=%0b err=%0b exp all 0",
               m0_rvalid, io_master_rready, busy, protocol_err);
    end
    io_master_rvalid = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    m1_arvalid = 1; m1_araddr = 32'h6000_0004;
    ar_q.push_back('{id: 4'd1, addr: 32'h6000_0004});
    #1;
    wait_arvalid(ok);
    checks++;
    if (!ok || io_master_arid !== 4'd1) begin
      failures++;
      $display("FAIL reset_regrant got ok=%0b arid=%0d exp 1/1", ok, io_master_arid);
    end
    @(negedge clock);
    m1_arvalid = 0;
    drive_beat(1'b1, 32'hE000_0001, 1'b1, 4'd1);
    @(negedge clock);
    io_master_rvalid = 0; io_master_rlast = 0;
    #1;
    checks++;
    if (protocol_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_regrant_done got err=%0b busy=%0b exp 0/0", protocol_err, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_m0_burst();
    test_write_first();
    test_protocol_err();
    test_reset_midburst();
    repeat (2) @(negedge clock);
    checks++;
    if (ar_q.size() != 0 || r_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got ar=%0d r=%0d exp 0/0", ar_q.size(), r_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-requester AXI4 arbiter between the fetch unit (M0, read-only, INCR bursts) and the load/store unit (M1, single-beat read or write). It feeds the single downstream AXI4 master port that goes to the crossbar and SoC. It grants one transaction at a time. Reads are granted round-robin, an M1 write is granted ahead of an M1 read, and R/B responses are routed back to the owner. It also flags protocol violations on the response side.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width DATA_W/8)
- ID_W, 4, AXI ID width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_arvalid/m0_arready  in/out  1  fetch AR handshake
- m0_araddr  in  ADDR_W; m0_arlen in 8; m0_arsize in 3; m0_arburst in 2
- m0_rvalid/m0_rready  out/in  1; m0_rdata out DATA_W; m0_rresp out 2; m0_rlast out 1
- m1_arvalid/m1_arready  in/out  1; m1_araddr in ADDR_W (single beat, size 3'b010)
- m1_rvalid/m1_rready  out/in  1; m1_rdata out DATA_W; m1_rresp out 2
- m1_awvalid/m1_awready, m1_wvalid/m1_wready  in/out  1; m1_awaddr in ADDR_W; m1_wdata in DATA_W; m1_wstrb in DATA_W/8
- m1_bvalid/m1_bready  out/in  1; m1_bresp out 2
- io_master_* (ar/r/aw/w/b, AXI4 subset incl. arid/arlen/arsize/arburst/rid/rlast/awid/bid/wlast)  out/in  as AXI4  downstream port
- busy  out  1  FSM not IDLE
- protocol_err  out  1  sticky, cleared only by reset

## Operation
- FSM states: IDLE, AR0, R0, AR1, R1, WR, WB.
- IDLE to WR when m1_awvalid. Otherwise pick between m0_arvalid and m1_arvalid by round-robin and go to AR0 or AR1.
- Round-robin pointer prefers M0 after reset. It flips to the other master whenever a read grant is taken.
- AR states: downstream AR fields are passed through from the granted requester.
  - arid = 0 for M0, 1 for M1.
  - M1 forces arlen 0, arsize 3'b010, arburst 2'b01.
  - Handshake: arvalid/arready are connected only to the granted master. On the handshake, latch arlen, load beat counter = arlen, and move to R0/R1.
- R states: rdata, rresp, rlast and rvalid go to the owner; rready comes from the owner. The other master sees rvalid = 0.
  - On each beat, decrement the counter. On a beat with rlast, return to IDLE.
- Write:
  - WR passes AW and W through independently, tracked by flags aw_done and w_done.
  - awid = 1, awlen = 0, awsize 3'b010, awburst 2'b01, wlast = 1.
  - When both flags are set, or set in the same cycle, go to WB.
  - WB routes bvalid/bresp to M1 and bready from M1. Return to IDLE on the handshake.
- protocol_err is set by any of:
  - rvalid or bvalid in IDLE, AR*, or WR;
  - rid/bid different from the issued ID;
  - rlast with counter ≠ 0;
  - counter = 0 beat without rlast.
  - The beat is still forwarded.
- Ungranted requesters see all readies low and all response valids low.

## Timing
- Reset (async assert, sync deassert):
  - state = IDLE, pointer = M0, aw_done = w_done = 0, busy = 0, protocol_err = 0.
  - All valid/ready outputs are 0.
  - An in-flight transaction is dropped; no pending response is kept.
- Grant latency: requester valid sampled in IDLE at cycle N; downstream valid is asserted at cycle N+1 at the earliest.
- Forwarding is combinational through the registered state; no data registers are in the R/W path.
- There is exactly one IDLE cycle between consecutive transactions.
- Requesters hold valid until ready (AXI rule). A valid that drops before grant is simply not served.
- Simultaneous requests in IDLE:
  - The write wins over both reads.
  - Between the reads, the pointer decides.
- The counter is 8 bits, loaded from arlen, and never wraps. Underflow is blocked by the error check.

## Structure
- Shared package:
  - state enum;
  - ID constants ID_M0 = 0, ID_M1 = 1;
  - AXI constants: SIZE_4B = 3'b010, BURST_INCR = 2'b01, RESP_OKAY = 2'b00.
- One sub-module, axi_arb_beat_check: beat counter, rlast/ID checking, sticky protocol_err.
- Grant FSM and channel muxing stay in the top module.

## Test plan
- M0 arlen = 3 at 0x3000_0000; downstream returns 4 beats with rlast on the 4th.
  - Required: M0 gets 4 beats, protocol_err = 0.
  - Required: busy returns to 0 on the cycle after the 4th beat.
- M0 and M1 arvalid in the same IDLE cycle after reset, then repeated.
  - Required: M0 is granted first (arid 0), then M1 (arid 1); order alternates.
- M1 awvalid and m1_arvalid together, W arriving 3 cycles after AW.
  - Required: the write is issued first with wlast = 1 and wstrb 4'b0011 preserved.
  - Required: B goes to M1; the read starts only after bready·bvalid.
- Downstream returns rlast on beat 2 of an arlen = 3 burst, or rid = 5.
  - Required: protocol_err rises and stays 1 until reset.
- reset driven low while in R0 after 1 of 4 beats.
  - Required: all outputs are 0 asynchronously; after release, a new M1 read is granted normally.
